// File: rtl/rom_load_ctrl.sv
// Loads SoC game-ROM bytes into NES PRG/CHR ROM: strobe edge detect -> request FIFO -> WR_PULSE-wide write; NES held in reset while loading.
// Latency: we rises 2 cycles after the edge cycle when idle; full FIFO drops requests (sticky overflow). Optional checksum output: ROM_LOAD_CHECKSUM_EN.
module rom_load_ctrl #(
    parameter int unsigned FIFO_DEPTH   = 4,
    parameter int unsigned WR_PULSE     = 4,
    parameter int unsigned IDLE_TIMEOUT = 1024,
    parameter int unsigned RESET_HOLD   = 16,
    parameter int unsigned PRG_BYTES    = 32768,
    parameter int unsigned CHR_BYTES    = 8192
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        prg_wren,
    input  logic        chr_wren,
    input  logic [15:0] prgmr_addr,
    input  logic [7:0]  prgmr_data,
    output logic        prg_rom_we,
    output logic        chr_rom_we,
    output logic [15:0] rom_wr_addr,
    output logic [7:0]  rom_wr_data,
    output logic        nes_reset,
    output logic        loading,
    output logic        load_done,
    output logic [15:0] prg_count,
    output logic [15:0] chr_count,
    output logic        overflow,
    output logic        range_err
`ifdef ROM_LOAD_CHECKSUM_EN
    ,
    output logic [7:0]  checksum
`endif
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int IW = $clog2(IDLE_TIMEOUT + 1);
    localparam int HW = $clog2(RESET_HOLD + 1);
    localparam int CW = $clog2(WR_PULSE + 1);

    localparam logic [1:0] ST_RUN  = 2'd0;
    localparam logic [1:0] ST_LOAD = 2'd1;
    localparam logic [1:0] ST_HOLD = 2'd2;

    logic          prg_prev_q, chr_prev_q;
    logic [AW:0]   wr_ptr_q, rd_ptr_q, wr_ptr_d, rd_ptr_d;
    logic          mem_typ  [FIFO_DEPTH];
    logic [15:0]   mem_addr [FIFO_DEPTH];
    logic [7:0]    mem_data [FIFO_DEPTH];
    logic [1:0]    state_q, state_d;
    logic [IW-1:0] idle_q, idle_d;
    logic [HW-1:0] hold_q, hold_d;
    logic          done_q, done_d;
    logic [CW-1:0] eng_cnt_q, eng_cnt_d;
    logic          prg_we_q, prg_we_d, chr_we_q, chr_we_d;
    logic [15:0]   wr_addr_q, wr_addr_d;
    logic [7:0]    wr_data_q, wr_data_d;
    logic [15:0]   prg_cnt_q, prg_cnt_d, chr_cnt_q, chr_cnt_d;
    logic [15:0]   prg_base, chr_base;
    logic          ovf_q, ovf_d, rerr_q, rerr_d;

    logic prg_edge, chr_edge, req, both, push_req, push, drop, pop, pop_ok, pop_bad;
    logic empty, full, clr, eng_busy;
    logic head_typ;
    logic [15:0] head_addr;
    logic [7:0]  head_data;

    assign prg_edge = prg_wren & ~prg_prev_q;
    assign chr_edge = chr_wren & ~chr_prev_q;
    assign req      = prg_edge | chr_edge;
    assign both     = prg_edge & chr_edge;
    assign push_req = req & ~both;

    assign empty = (wr_ptr_q == rd_ptr_q);
    assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

    assign head_typ  = mem_typ[rd_ptr_q[AW-1:0]];
    assign head_addr = mem_addr[rd_ptr_q[AW-1:0]];
    assign head_data = mem_data[rd_ptr_q[AW-1:0]];

    assign eng_busy = (eng_cnt_q != '0);
    assign pop      = ~empty & ~eng_busy;
    // An out-of-range entry is still consumed, it just never reaches the ROM.
    assign pop_ok   = pop & (head_typ ? (32'(head_addr) < CHR_BYTES) : (32'(head_addr) < PRG_BYTES));
    assign pop_bad  = pop & ~pop_ok;
    assign push     = push_req & (~full | pop);
    assign drop     = push_req & full & ~pop;

    assign wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    assign rd_ptr_d = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;

    always_ff @(posedge Clk) begin
        if (push) begin
            mem_typ[wr_ptr_q[AW-1:0]]  <= chr_edge;
            mem_addr[wr_ptr_q[AW-1:0]] <= prgmr_addr;
            mem_data[wr_ptr_q[AW-1:0]] <= prgmr_data;
        end
    end

    always_comb begin
        state_d = state_q;
        idle_d  = idle_q;
        hold_d  = hold_q;
        done_d  = 1'b0;
        clr     = 1'b0;
        case (state_q)
            ST_RUN: begin
                if (req) begin
                    state_d = ST_LOAD;
                    idle_d  = '0;
                    clr     = 1'b1;
                end
            end
            ST_LOAD: begin
                if (req || !empty || eng_busy) begin
                    idle_d = '0;
                end else if (idle_q == IW'(IDLE_TIMEOUT - 1)) begin
                    state_d = ST_HOLD;
                    idle_d  = '0;
                    hold_d  = '0;
                    done_d  = 1'b1;
                end else begin
                    idle_d = idle_q + IW'(1);
                end
            end
            default: begin
                if (req) begin
                    state_d = ST_LOAD;
                    idle_d  = '0;
                    hold_d  = '0;
                end else if (hold_q == HW'(RESET_HOLD - 1)) begin
                    state_d = ST_RUN;
                end else begin
                    hold_d = hold_q + HW'(1);
                end
            end
        endcase
    end

    always_comb begin
        eng_cnt_d = eng_cnt_q;
        prg_we_d  = prg_we_q;
        chr_we_d  = chr_we_q;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;
        if (pop_ok) begin
            eng_cnt_d = CW'(WR_PULSE);
            prg_we_d  = ~head_typ;
            chr_we_d  = head_typ;
            wr_addr_d = head_addr;
            wr_data_d = head_data;
        end else if (eng_busy) begin
            // The cycle after the last we-high cycle is the mandatory gap.
            eng_cnt_d = eng_cnt_q - CW'(1);
            if (eng_cnt_q == CW'(1)) begin
                prg_we_d = 1'b0;
                chr_we_d = 1'b0;
            end
        end
    end

    always_comb begin
        prg_base  = clr ? 16'h0000 : prg_cnt_q;
        chr_base  = clr ? 16'h0000 : chr_cnt_q;
        prg_cnt_d = (pop_ok && !head_typ && prg_base != 16'hFFFF) ? prg_base + 16'd1 : prg_base;
        chr_cnt_d = (pop_ok && head_typ && chr_base != 16'hFFFF) ? chr_base + 16'd1 : chr_base;
        ovf_d     = (clr ? 1'b0 : ovf_q) | drop;
        rerr_d    = (clr ? 1'b0 : rerr_q) | both | pop_bad;
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            prg_prev_q <= 1'b0;
            chr_prev_q <= 1'b0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            state_q    <= ST_HOLD;
            idle_q     <= '0;
            hold_q     <= '0;
            done_q     <= 1'b0;
            eng_cnt_q  <= '0;
            prg_we_q   <= 1'b0;
            chr_we_q   <= 1'b0;
            wr_addr_q  <= '0;
            wr_data_q  <= '0;
            prg_cnt_q  <= '0;
            chr_cnt_q  <= '0;
            ovf_q      <= 1'b0;
            rerr_q     <= 1'b0;
        end else begin
            prg_prev_q <= prg_wren;
            chr_prev_q <= chr_wren;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            state_q    <= state_d;
            idle_q     <= idle_d;
            hold_q     <= hold_d;
            done_q     <= done_d;
            eng_cnt_q  <= eng_cnt_d;
            prg_we_q   <= prg_we_d;
            chr_we_q   <= chr_we_d;
            wr_addr_q  <= wr_addr_d;
            wr_data_q  <= wr_data_d;
            prg_cnt_q  <= prg_cnt_d;
            chr_cnt_q  <= chr_cnt_d;
            ovf_q      <= ovf_d;
            rerr_q     <= rerr_d;
        end
    end

`ifdef ROM_LOAD_CHECKSUM_EN
    logic [7:0] csum_q, csum_d;
    assign csum_d = (clr ? 8'h00 : csum_q) + (pop_ok ? head_data : 8'h00);
    always_ff @(posedge Clk) begin
        if (Reset) csum_q <= '0;
        else       csum_q <= csum_d;
    end
    assign checksum = csum_q;
`endif

    assign prg_rom_we  = prg_we_q;
    assign chr_rom_we  = chr_we_q;
    assign rom_wr_addr = wr_addr_q;
    assign rom_wr_data = wr_data_q;
    assign nes_reset   = (state_q != ST_RUN);
    assign loading     = (state_q == ST_LOAD);
    assign load_done   = done_q;
    assign prg_count   = prg_cnt_q;
    assign chr_count   = chr_cnt_q;
    assign overflow    = ovf_q;
    assign range_err   = rerr_q;
endmodule

// File: tb/tb_rom_load_ctrl.sv
// Directed bench for rom_load_ctrl with hand-computed cycle expectations.
module tb_rom_load_ctrl;
    logic        Clk = 1'b0;
    logic        Reset;
    logic        prg_wren, chr_wren;
    logic [15:0] prgmr_addr;
    logic [7:0]  prgmr_data;
    logic        prg_rom_we, chr_rom_we;
    logic [15:0] rom_wr_addr;
    logic [7:0]  rom_wr_data;
    logic        nes_reset, loading, load_done;
    logic [15:0] prg_count, chr_count;
    logic        overflow, range_err;
`ifdef ROM_LOAD_CHECKSUM_EN
    logic [7:0]  checksum;
`endif

    int checks = 0;
    int errors = 0;

    rom_load_ctrl dut (
        .Clk        (Clk),
        .Reset      (Reset),
        .prg_wren   (prg_wren),
        .chr_wren   (chr_wren),
        .prgmr_addr (prgmr_addr),
        .prgmr_data (prgmr_data),
        .prg_rom_we (prg_rom_we),
        .chr_rom_we (chr_rom_we),
        .rom_wr_addr(rom_wr_addr),
        .rom_wr_data(rom_wr_data),
        .nes_reset  (nes_reset),
        .loading    (loading),
        .load_done  (load_done),
        .prg_count  (prg_count),
        .chr_count  (chr_count),
        .overflow   (overflow),
`ifdef ROM_LOAD_CHECKSUM_EN
        .checksum   (checksum),
`endif
        .range_err  (range_err)
    );

    always #5 Clk = ~Clk;

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Two reset cycles, then 16 HOLD cycles: returns in the first RUN cycle.
    task automatic do_reset();
        Reset = 1'b1;
        tick();
        tick();
        Reset = 1'b0;
        repeat (16) tick();
    endtask

    initial begin
        int nwe;
        int nst;
        int st_cyc [8];
        logic [15:0] st_addr [8];
        logic [7:0]  st_data [8];
        logic prev_we;

        Reset = 1'b1; prg_wren = 1'b0; chr_wren = 1'b0;
        prgmr_addr = 16'h0000; prgmr_data = 8'h00;
        tick(); tick(); tick();
        check("rst_nes_reset", 32'(nes_reset), 32'd1);
        check("rst_prg_we",    32'(prg_rom_we), 32'd0);
        check("rst_chr_we",    32'(chr_rom_we), 32'd0);
        check("rst_loading",   32'(loading), 32'd0);
        check("rst_load_done", 32'(load_done), 32'd0);
        check("rst_prg_count", 32'(prg_count), 32'd0);
        check("rst_chr_count", 32'(chr_count), 32'd0);
        check("rst_overflow",  32'(overflow), 32'd0);
        check("rst_range_err", 32'(range_err), 32'd0);

        // Release: first HOLD cycle is now, 16 cycles total.
        Reset = 1'b0;
        repeat (15) tick();
        check("hold_last_cycle", 32'(nes_reset), 32'd1);
        tick();
        check("hold_released", 32'(nes_reset), 32'd0);

        // Single PRG write from RUN; edge cycle is now.
        prg_wren = 1'b1; prgmr_addr = 16'h0010; prgmr_data = 8'hA5;
        tick();
        check("w1_nes_reset", 32'(nes_reset), 32'd1);
        check("w1_loading",   32'(loading), 32'd1);
        check("w1_we_early",  32'(prg_rom_we), 32'd0);
        prg_wren = 1'b0;
        tick();
        check("w1_we_rise", 32'(prg_rom_we), 32'd1);
        check("w1_addr",    32'(rom_wr_addr), 32'h0010);
        check("w1_data",    32'(rom_wr_data), 32'hA5);
        check("w1_count",   32'(prg_count), 32'd1);
        repeat (3) tick();
        check("w1_we_last", 32'(prg_rom_we), 32'd1);
        tick();
        check("w1_we_fall", 32'(prg_rom_we), 32'd0);
        repeat (1023) tick();
        check("w1_done_not_yet", 32'(load_done), 32'd0);
        tick();
        check("w1_load_done", 32'(load_done), 32'd1);
        check("w1_hold_loading", 32'(loading), 32'd0);
        check("w1_hold_nes", 32'(nes_reset), 32'd1);
        tick();
        check("w1_done_pulse", 32'(load_done), 32'd0);
        repeat (14) tick();
        check("w1_hold_end", 32'(nes_reset), 32'd1);
        tick();
        check("w1_run", 32'(nes_reset), 32'd0);
        check("w1_count_kept", 32'(prg_count), 32'd1);

        // Strobe held high for 10 cycles: one write only.
        prg_wren = 1'b1; prgmr_addr = 16'h0020; prgmr_data = 8'h11;
        nwe = 0;
        repeat (10) begin
            tick();
            if (prg_rom_we) nwe++;
        end
        prg_wren = 1'b0;
        check("level_we_cycles", 32'(nwe), 32'd4);
        check("level_count", 32'(prg_count), 32'd1);

        // 8 rises every 2 cycles: 7 written in order, last one dropped.
        do_reset();
        nst = 0;
        prev_we = 1'b0;
        for (int cyc = 0; cyc < 50; cyc++) begin
            if (prg_rom_we && !prev_we && nst < 8) begin
                st_cyc[nst]  = cyc;
                st_addr[nst] = rom_wr_addr;
                st_data[nst] = rom_wr_data;
                nst++;
            end
            prev_we = prg_rom_we;
            prg_wren   = (cyc < 16) && (cyc % 2 == 0);
            prgmr_addr = 16'h0100 + 16'(cyc / 2);
            prgmr_data = 8'h30 + 8'(cyc / 2);
            tick();
        end
        prg_wren = 1'b0;
        check("burst_nwrites", 32'(nst), 32'd7);
        check("burst_overflow", 32'(overflow), 32'd1);
        check("burst_count", 32'(prg_count), 32'd7);
        for (int k = 0; k < 7; k++) begin
            check($sformatf("burst_start%0d", k), 32'(st_cyc[k]), 32'(2 + 5 * k));
            check($sformatf("burst_addr%0d", k), 32'(st_addr[k]), 32'h0100 + 32'(k));
            check($sformatf("burst_data%0d", k), 32'(st_data[k]), 32'h30 + 32'(k));
        end

        // CHR out of range, then the last valid CHR address, then PRG just past range.
        do_reset();
        chr_wren = 1'b1; prgmr_addr = 16'h2000; prgmr_data = 8'h55;
        nwe = 0;
        repeat (6) begin
            tick();
            if (chr_rom_we) nwe++;
        end
        chr_wren = 1'b0;
        check("chr_oor_we", 32'(nwe), 32'd0);
        check("chr_oor_err", 32'(range_err), 32'd1);
        check("chr_oor_count", 32'(chr_count), 32'd0);
        tick();
        chr_wren = 1'b1; prgmr_addr = 16'h1FFF; prgmr_data = 8'h77;
        tick();
        tick();
        chr_wren = 1'b0;
        check("chr_edge_we", 32'(chr_rom_we), 32'd1);
        check("chr_edge_addr", 32'(rom_wr_addr), 32'h1FFF);
        check("chr_edge_data", 32'(rom_wr_data), 32'h77);
        check("chr_edge_count", 32'(chr_count), 32'd1);
        prg_wren = 1'b1; prgmr_addr = 16'h8000; prgmr_data = 8'h99;
        nwe = 0;
        repeat (8) begin
            tick();
            if (prg_rom_we) nwe++;
        end
        prg_wren = 1'b0;
        check("prg_oor_we", 32'(nwe), 32'd0);
        check("prg_oor_count", 32'(prg_count), 32'd0);

        // Both strobes rising together.
        do_reset();
        check("both_pre_err", 32'(range_err), 32'd0);
        prg_wren = 1'b1; chr_wren = 1'b1; prgmr_addr = 16'h0001; prgmr_data = 8'h01;
        nwe = 0;
        repeat (6) begin
            tick();
            if (prg_rom_we || chr_rom_we) nwe++;
        end
        prg_wren = 1'b0; chr_wren = 1'b0;
        check("both_we", 32'(nwe), 32'd0);
        check("both_err", 32'(range_err), 32'd1);
        check("both_prg_count", 32'(prg_count), 32'd0);
        check("both_chr_count", 32'(chr_count), 32'd0);

        // Reset in the middle of a write pulse.
        do_reset();
        prg_wren = 1'b1; prgmr_addr = 16'h0005; prgmr_data = 8'h3C;
        tick();
        prg_wren = 1'b0;
        tick();
        check("midrst_we_on", 32'(prg_rom_we), 32'd1);
        tick();
        Reset = 1'b1;
        tick();
        check("midrst_we_off", 32'(prg_rom_we), 32'd0);
        check("midrst_count", 32'(prg_count), 32'd0);
        check("midrst_nes", 32'(nes_reset), 32'd1);
        Reset = 1'b0;

`ifdef ROM_LOAD_CHECKSUM_EN
        do_reset();
        prg_wren = 1'b1; prgmr_addr = 16'h0010; prgmr_data = 8'hFF;
        tick();
        prg_wren = 1'b0;
        tick();
        prg_wren = 1'b1; prgmr_addr = 16'h0011; prgmr_data = 8'h02;
        tick();
        prg_wren = 1'b0;
        repeat (12) tick();
        check("csum_value", 32'(checksum), 32'h01);
        check("csum_count", 32'(prg_count), 32'd2);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
